// File: rtl/semaforo_pkg.sv
// Shared types and constants for the semaforo intersection controller.
// Phase states, lamp encodings and a width helper for the phase timer.
package semaforo_pkg;

  typedef enum logic [2:0] {
    ST_ALL_RED_A   = 3'd0,
    ST_MAIN_GREEN  = 3'd1,
    ST_MAIN_YELLOW = 3'd2,
    ST_ALL_RED_B   = 3'd3,
    ST_SIDE_GREEN  = 3'd4,
    ST_SIDE_YELLOW = 3'd5,
    ST_MANUAL      = 3'd6
  } sem_state_t;

  typedef logic [2:0] lamp_t;

  localparam lamp_t LAMP_RED    = 3'b100;
  localparam lamp_t LAMP_YELLOW = 3'b010;
  localparam lamp_t LAMP_GREEN  = 3'b001;
  localparam lamp_t LAMP_OFF    = 3'b000;

  function automatic int unsigned max_of5(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d,
                                          input int unsigned e);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/semaforo_phase_timer.sv
// Loadable phase down-counter; saturates at zero so an open-ended phase
// (main green waiting for a request) can sit at zero without wrapping.
module semaforo_phase_timer #(
  parameter int unsigned      W       = 4,
  parameter logic [W-1:0]     RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                count <= RST_VAL;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/semaforo_intersection_ctrl.sv
// Two-way intersection phase sequencer with manual flashing override.
// Pedestrian request/walk logic is built only when SEMAFORO_PED_WALK_EN is defined.
module semaforo_intersection_ctrl
  import semaforo_pkg::*;
#(
  parameter int unsigned MIN_GREEN  = 8,
  parameter int unsigned SIDE_GREEN = 6,
  parameter int unsigned YELLOW     = 3,
  parameter int unsigned ALL_RED    = 2,
  parameter int unsigned FLASH      = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  side_req,
  input  logic  ped_req,
  input  logic  manual_en,
  output lamp_t main_lamp,
  output lamp_t side_lamp,
  output logic  ped_walk,
  output logic  ped_ack
);

  localparam int unsigned CW = $clog2(max_of5(MIN_GREEN, SIDE_GREEN, YELLOW, ALL_RED, FLASH)) + 1;

  localparam logic [CW-1:0] LD_MIN_GREEN  = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] LD_SIDE_GREEN = CW'(SIDE_GREEN - 1);
  localparam logic [CW-1:0] LD_YELLOW     = CW'(YELLOW - 1);
  localparam logic [CW-1:0] LD_ALL_RED    = CW'(ALL_RED - 1);
  localparam logic [CW-1:0] LD_FLASH      = CW'(FLASH - 1);

  sem_state_t    state, state_next;
  logic          flash_red, flash_red_next;
  logic          tmr_load, tmr_zero;
  logic [CW-1:0] tmr_val;
  logic          req_any;

  semaforo_phase_timer #(
    .W       (CW),
    .RST_VAL (LD_ALL_RED)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ALL_RED_A;
      flash_red <= 1'b0;
    end else begin
      state     <= state_next;
      flash_red <= flash_red_next;
    end
  end

  // Every exit loads the next phase's duration in the same cycle, so the
  // counter never needs to wrap.
  always_comb begin
    state_next     = state;
    tmr_load       = 1'b0;
    tmr_val        = LD_ALL_RED;
    flash_red_next = flash_red;
    if (manual_en) begin
      if (state != ST_MANUAL) begin
        state_next     = ST_MANUAL;
        tmr_load       = 1'b1;
        tmr_val        = LD_FLASH;
        flash_red_next = 1'b0;
      end else if (tmr_zero) begin
        tmr_load       = 1'b1;
        tmr_val        = LD_FLASH;
        flash_red_next = ~flash_red;
      end
    end else begin
      case (state)
        ST_ALL_RED_A: if (tmr_zero) begin
          state_next = ST_MAIN_GREEN;
          tmr_load   = 1'b1;
          tmr_val    = LD_MIN_GREEN;
        end
        ST_MAIN_GREEN: if (tmr_zero && req_any) begin
          state_next = ST_MAIN_YELLOW;
          tmr_load   = 1'b1;
          tmr_val    = LD_YELLOW;
        end
        ST_MAIN_YELLOW: if (tmr_zero) begin
          state_next = ST_ALL_RED_B;
          tmr_load   = 1'b1;
          tmr_val    = LD_ALL_RED;
        end
        ST_ALL_RED_B: if (tmr_zero) begin
          state_next = ST_SIDE_GREEN;
          tmr_load   = 1'b1;
          tmr_val    = LD_SIDE_GREEN;
        end
        ST_SIDE_GREEN: if (tmr_zero) begin
          state_next = ST_SIDE_YELLOW;
          tmr_load   = 1'b1;
          tmr_val    = LD_YELLOW;
        end
        ST_SIDE_YELLOW: if (tmr_zero) begin
          state_next = ST_ALL_RED_A;
          tmr_load   = 1'b1;
          tmr_val    = LD_ALL_RED;
        end
        ST_MANUAL: begin
          state_next = ST_ALL_RED_A;
          tmr_load   = 1'b1;
          tmr_val    = LD_ALL_RED;
        end
        default: begin
          state_next = ST_ALL_RED_A;
          tmr_load   = 1'b1;
          tmr_val    = LD_ALL_RED;
        end
      endcase
    end
  end

  always_comb begin
    main_lamp = LAMP_RED;
    side_lamp = LAMP_RED;
    case (state)
      ST_MAIN_GREEN:  main_lamp = LAMP_GREEN;
      ST_MAIN_YELLOW: main_lamp = LAMP_YELLOW;
      ST_SIDE_GREEN:  side_lamp = LAMP_GREEN;
      ST_SIDE_YELLOW: side_lamp = LAMP_YELLOW;
      ST_MANUAL: begin
        main_lamp = flash_red ? LAMP_RED : LAMP_YELLOW;
        side_lamp = flash_red ? LAMP_RED : LAMP_YELLOW;
      end
      default: begin
        main_lamp = LAMP_RED;
        side_lamp = LAMP_RED;
      end
    endcase
  end

`ifdef SEMAFORO_PED_WALK_EN
  logic ped_pending, ped_ack_q;
  logic sg_entry, pending_eff, ped_accept;

  // Entry to side green clears pending before a same-cycle request is
  // evaluated, so that request is accepted and earns one more side cycle.
  assign sg_entry    = (state_next == ST_SIDE_GREEN) && (state != ST_SIDE_GREEN);
  assign pending_eff = ped_pending && !sg_entry;
  assign ped_accept  = ped_req && !pending_eff && !manual_en && (state != ST_MANUAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ped_pending <= 1'b0;
      ped_ack_q   <= 1'b0;
    end else begin
      ped_ack_q <= ped_accept;
      if (manual_en || state == ST_MANUAL) ped_pending <= 1'b0;
      else                                 ped_pending <= pending_eff || ped_accept;
    end
  end

  assign req_any  = side_req || ped_pending;
  assign ped_walk = (state == ST_SIDE_GREEN);
  assign ped_ack  = ped_ack_q;
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign req_any        = side_req;
  assign ped_walk       = 1'b0;
  assign ped_ack        = 1'b0;
`endif

endmodule
